pipe_elastic_buffer: RTL
========================

PIPE_ELASTIC_BUFFER -- requirements
Module: pipe_elastic_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning payload bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entry count; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1, producer offers in_data.
REQ-007 The block SHALL have port in_data, input, WIDTH, producer payload.
REQ-008 The block SHALL have port in_ready, output, 1, buffer accepts a push this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, out_data holds the oldest entry.
REQ-010 The block SHALL have port out_data, output, WIDTH, oldest entry payload.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts a pop this cycle.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-013 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-014 in_ready SHALL be (count != DEPTH) && !flush, with no combinational path from out_ready.
REQ-015 out_valid SHALL be (count != 0); out_data SHALL be the entry at the read pointer, forced to 0 when count == 0.
REQ-016 A pushed word SHALL appear on out_data with out_valid high one cycle after the push edge (latency 1, no bypass).
REQ-017 Order SHALL be strict FIFO; each pushed word is popped exactly once unless flushed.
REQ-018 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 When full, a pop in the same cycle SHALL NOT enable a push (in_ready stays 0 that cycle).
REQ-021 When empty, out_ready high SHALL have no effect; count never underflows.
REQ-022 flush SHALL take priority over push and pop: next state count = 0, both pointers = 0, any same-cycle push discarded.
REQ-023 Data held with out_valid high and out_ready low SHALL remain stable until popped or flushed.

Reset
REQ-024 Asserting reset SHALL immediately force count = 0, pointers = 0, out_valid = 0, out_data = 0, in_ready = 1 (if flush low).
REQ-025 Storage array contents SHALL NOT require reset; they are never visible while count == 0.
REQ-026 Reset asserted mid-operation SHALL drop all entries; the first post-reset push is the next word observed.

Structure
REQ-027 Default WIDTH/DEPTH constants and the count-width function SHALL live in a shared pipeline package used by all stage buffers.
REQ-028 The storage array SHALL be a sub-module buffer_ram (WIDTH x DEPTH, one write port, one async read port); pointer/count control stays in pipe_elastic_buffer.

Verification (WIDTH=16, DEPTH=4)
REQ-029 Push 0x1111,0x2222,0x3333 with out_ready=0 -> count=3, out_data=0x1111 steady, in_ready=1.
REQ-030 Push 5 words back-to-back, out_ready=0 -> 5th refused (in_ready=0 at count=4), count=4; then pop all -> 0x0001..0x0004 in order, count=0, out_data=0.
REQ-031 Full buffer, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3, next cycle push accepted.
REQ-032 Count=2, push 0xAAAA and pop same cycle -> count stays 2; continue 10 cycles streaming -> pointers wrap, order preserved.
REQ-033 Count=3, flush=1 with in_valid=1 (0xBEEF) -> next cycle count=0, out_valid=0, 0xBEEF never emerges.
REQ-034 Count=2, reset driven low mid-cycle -> outputs zero before next edge; after release push 0x5A5A -> out_data=0x5A5A one cycle later.

Source files
------------

// File: rtl/pipe_elastic_buffer_pkg.sv
// Shared constants and sizing helpers for the pipeline stage buffers.
// Every stage buffer derives its default geometry and counter widths from here.
package pipe_elastic_buffer_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 2;

  // Occupancy must represent 0..depth inclusive, hence depth + 1 states.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? unsigned'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_buffer_ram.sv
// Storage array for pipe_elastic_buffer.
// It has one synchronous write port and one asynchronous read port, and its contents are not reset.
module buffer_ram
  import pipe_elastic_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_elastic_buffer.sv
// Elastic FIFO buffer between pipeline stages, with valid/ready on both sides.
// It has one cycle of latency and no bypass, and flush takes priority over push and pop.
module pipe_elastic_buffer
  import pipe_elastic_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] rd_data;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // in_ready depends only on registered state and flush, so a pop cannot free a slot the same cycle.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  buffer_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Stale storage must never leak out while the buffer is empty.
  assign out_data = empty ? '0 : rd_data;
  assign count    = count_q;

endmodule
